// File: rtl/gshare_branch_predictor_if.sv
// rtl/gshare_branch_predictor_if.sv - prediction/resolution bus for the gshare branch predictor
interface gshare_branch_predictor_if;
  logic        pred_valid;
  logic [31:0] pred_pc;
  logic        pred_ready;
  logic        pred_taken;
  logic        res_valid;
  logic        res_taken;
  logic        res_ready;
  logic        mispredict;
  logic [31:0] count_total;
  logic [31:0] count_correct;

  modport master (
    output pred_valid, pred_pc, res_valid, res_taken,
    input  pred_ready, pred_taken, res_ready, mispredict, count_total, count_correct
  );

  modport slave (
    input  pred_valid, pred_pc, res_valid, res_taken,
    output pred_ready, pred_taken, res_ready, mispredict, count_total, count_correct
  );
endinterface

// File: rtl/gshare_branch_predictor.sv
// rtl/gshare_branch_predictor.sv - gshare predictor with speculative history and pending-branch FIFO
module gshare_branch_predictor #(
  parameter int R    = 8,
  parameter int H    = 4,
  parameter int N    = 2,
  parameter int D    = 4,
  parameter int HASH = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  gshare_branch_predictor_if.slave    bus
);
  localparam int TBL = 1 << R;
  localparam int AW  = $clog2(D);
  localparam int CW  = AW + 1;
  localparam logic [N-1:0] CTR_INIT = N'((1 << (N - 1)) - 1);
  localparam logic [N-1:0] CTR_MAX  = {N{1'b1}};

  logic [N-1:0]  table_q [TBL];
  logic [R-1:0]  fifo_idx [D];
  logic          fifo_pred [D];
  logic [H-1:0]  fifo_snap [D];

  logic [H-1:0]  ghr;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          mispredict_q;
  logic [31:0]   total_q;
  logic [31:0]   correct_q;

  logic [R-1:0]  ghr_ext;
  logic [R-1:0]  pred_idx;
  logic          pred_bit;
  logic          fifo_full;
  logic          fifo_empty;
  logic          resolve;
  logic          mispred;
  logic          accept;
  logic [R-1:0]  head_idx;
  logic          head_pred;
  logic [H-1:0]  head_snap;
  logic [N-1:0]  head_ctr;
  logic [N-1:0]  ctr_next;
  logic [H:0]    ghr_spec_wide;
  logic [H:0]    ghr_fix_wide;
  logic          unused_pc;

  // Only PC bits feeding the index matter; fold the rest into a sink.
  assign unused_pc = ^bus.pred_pc;

  // Zero-extend the history to the table index width for the XOR hash.
  always_comb begin
    ghr_ext = '0;
    ghr_ext[H-1:0] = ghr;
  end

  generate
    if (HASH == 0) begin : g_concat
      if (H == R) begin : g_hist_only
        assign pred_idx = ghr;
      end else begin : g_hist_pc
        assign pred_idx = {ghr, bus.pred_pc[R-H+1:2]};
      end
    end else begin : g_xor
      assign pred_idx = bus.pred_pc[R+1:2] ^ ghr_ext;
    end
  endgenerate

  assign pred_bit   = table_q[pred_idx][N-1];
  assign fifo_full  = (count == CW'(D));
  assign fifo_empty = (count == '0);
  assign head_idx   = fifo_idx[rd_ptr];
  assign head_pred  = fifo_pred[rd_ptr];
  assign head_snap  = fifo_snap[rd_ptr];
  assign head_ctr   = table_q[head_idx];

  assign resolve = bus.res_valid && !fifo_empty;
  assign mispred = resolve && (bus.res_taken != head_pred);
  assign accept  = bus.pred_valid && !fifo_full && !mispred;

  assign bus.pred_taken    = pred_bit;
  assign bus.pred_ready    = !fifo_full && !mispred;
  assign bus.res_ready     = !fifo_empty;
  assign bus.mispredict    = mispredict_q;
  assign bus.count_total   = total_q;
  assign bus.count_correct = correct_q;

  // Histories: speculative shift on accept, repair from the head snapshot on mispredict.
  assign ghr_spec_wide = {ghr, pred_bit};
  assign ghr_fix_wide  = {head_snap, bus.res_taken};

  // Saturating step of the resolved branch's counter toward the actual outcome.
  always_comb begin
    ctr_next = head_ctr;
    if (bus.res_taken) begin
      if (head_ctr != CTR_MAX) ctr_next = head_ctr + N'(1);
    end else begin
      if (head_ctr != '0) ctr_next = head_ctr - N'(1);
    end
  end

  // Pattern table: trained only by resolutions, never bypassed into the same-cycle read.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < TBL; i++) table_q[i] <= CTR_INIT;
    end else if (resolve) begin
      table_q[head_idx] <= ctr_next;
    end
  end

  // Pending-branch payload storage; validity is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (accept) begin
      fifo_idx[wr_ptr]  <= pred_idx;
      fifo_pred[wr_ptr] <= pred_bit;
      fifo_snap[wr_ptr] <= ghr;
    end
  end

  // FIFO pointers, occupancy and global history.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ghr    <= '0;
    end else if (mispred) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ghr    <= ghr_fix_wide[H-1:0];
    end else begin
      if (accept) begin
        wr_ptr <= wr_ptr + AW'(1);
        ghr    <= ghr_spec_wide[H-1:0];
      end
      if (resolve) rd_ptr <= rd_ptr + AW'(1);
      if (accept && !resolve) count <= count + CW'(1);
      else if (resolve && !accept) count <= count - CW'(1);
    end
  end

  // Statistics and the registered mispredict pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      total_q      <= '0;
      correct_q    <= '0;
      mispredict_q <= 1'b0;
    end else begin
      mispredict_q <= mispred;
      if (resolve) begin
        total_q <= total_q + 32'd1;
        if (!mispred) correct_q <= correct_q + 32'd1;
      end
    end
  end
endmodule

// File: tb/tb_gshare_branch_predictor.sv
// tb/tb_gshare_branch_predictor.sv - bench for gshare_branch_predictor, concat and gshare hashing
module tb_gshare_branch_predictor;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic        pred_valid = 1'b0;
  logic [31:0] pred_pc = '0;
  logic        res_valid = 1'b0;
  logic        res_taken = 1'b0;

  int nvec = 0;
  int nmis = 0;
  bit checking = 1'b0;

  always #5 clk = ~clk;

  gshare_branch_predictor_if bus0 ();
  gshare_branch_predictor_if bus1 ();

  assign bus0.pred_valid = pred_valid;
  assign bus0.pred_pc    = pred_pc;
  assign bus0.res_valid  = res_valid;
  assign bus0.res_taken  = res_taken;
  assign bus1.pred_valid = pred_valid;
  assign bus1.pred_pc    = pred_pc;
  assign bus1.res_valid  = res_valid;
  assign bus1.res_taken  = res_taken;

  gshare_branch_predictor #(.HASH(0)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
  gshare_branch_predictor #(.HASH(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

  logic        act_pt  [2];
  logic        act_pr  [2];
  logic        act_rr  [2];
  logic        act_mp  [2];
  logic [31:0] act_tot [2];
  logic [31:0] act_cor [2];
  assign act_pt[0] = bus0.pred_taken;   assign act_pt[1] = bus1.pred_taken;
  assign act_pr[0] = bus0.pred_ready;   assign act_pr[1] = bus1.pred_ready;
  assign act_rr[0] = bus0.res_ready;    assign act_rr[1] = bus1.res_ready;
  assign act_mp[0] = bus0.mispredict;   assign act_mp[1] = bus1.mispredict;
  assign act_tot[0] = bus0.count_total;   assign act_tot[1] = bus1.count_total;
  assign act_cor[0] = bus0.count_correct; assign act_cor[1] = bus1.count_correct;

  // Reference model: one pattern table, history and pending list per instance.
  typedef struct { int idx; bit pred; int snap; } entry_t;
  int     tbl_m [2][256];
  int     ghr_m [2];
  entry_t q_m   [2][$];
  int     tot_m [2];
  int     cor_m [2];
  bit     mis_m [2];

  function automatic int idx_of(int i, logic [31:0] pc, int g);
    int word = int'(pc >> 2);
    if (i == 0) return (g * 16) + (word % 16);
    return (word % 256) ^ g;
  endfunction

  function automatic bit exp_pred(int i);
    return tbl_m[i][idx_of(i, pred_pc, ghr_m[i])] >= 2;
  endfunction

  function automatic bit exp_ready(int i);
    bit wrong = res_valid && (q_m[i].size() > 0) && (res_taken != q_m[i][0].pred);
    return (q_m[i].size() < 4) && !wrong;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 256; k++) tbl_m[i][k] = 1;
      ghr_m[i] = 0;
      q_m[i].delete();
      tot_m[i] = 0;
      cor_m[i] = 0;
      mis_m[i] = 1'b0;
    end
  endtask

  task automatic model_step(int i);
    bit rs   = res_valid && (q_m[i].size() > 0);
    bit acc  = pred_valid && exp_ready(i);
    bit p    = exp_pred(i);
    int idx  = idx_of(i, pred_pc, ghr_m[i]);
    bit mis  = 1'b0;
    entry_t e;
    if (rs) begin
      e = q_m[i].pop_front();
      mis = (res_taken != e.pred);
      if (res_taken) tbl_m[i][e.idx] = (tbl_m[i][e.idx] == 3) ? 3 : tbl_m[i][e.idx] + 1;
      else           tbl_m[i][e.idx] = (tbl_m[i][e.idx] == 0) ? 0 : tbl_m[i][e.idx] - 1;
      tot_m[i]++;
      if (!mis) cor_m[i]++;
    end
    mis_m[i] = mis;
    if (mis) begin
      q_m[i].delete();
      ghr_m[i] = ((e.snap * 2) + int'(res_taken)) % 16;
    end else if (acc) begin
      q_m[i].push_back('{idx: idx, pred: p, snap: ghr_m[i]});
      ghr_m[i] = ((ghr_m[i] * 2) + int'(p)) % 16;
    end
  endtask

  task automatic check(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s inst%0d: got 0x%0h, expected 0x%0h", name, i, act, exp);
    end
  endtask

  // Model advances on the same edges as the DUT, and clears on asynchronous reset.
  initial begin
    model_clear();
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) model_clear();
      else begin
        model_step(0);
        model_step(1);
      end
    end
  end

  // Every cycle, compare all outputs of both instances against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (checking) begin
        for (int i = 0; i < 2; i++) begin
          check("pred_taken", i, act_pt[i], 32'(exp_pred(i)));
          check("pred_ready", i, act_pr[i], 32'(exp_ready(i)));
          check("res_ready", i, act_rr[i], 32'(q_m[i].size() > 0));
          check("mispredict", i, act_mp[i], 32'(mis_m[i]));
          check("count_total", i, act_tot[i], tot_m[i]);
          check("count_correct", i, act_cor[i], cor_m[i]);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  task automatic drive(input bit pv, input logic [31:0] pc, input bit rv, input bit rt);
    pred_valid = pv;
    pred_pc    = pc;
    res_valid  = rv;
    res_taken  = rt;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  task automatic pair(input logic [31:0] pc, input bit t);
    drive(1'b1, pc, 1'b0, 1'b0); step();
    drive(1'b0, pc, 1'b1, t);    step();
    drive(1'b0, pc, 1'b0, 1'b0); step();
  endtask

  initial begin
    do_reset();
    checking = 1'b1;

    // Reset state.
    drive(1'b0, 32'h100, 1'b0, 1'b0); #1;
    for (int i = 0; i < 2; i++) begin
      check("rst_pred_taken", i, act_pt[i], 0);
      check("rst_pred_ready", i, act_pr[i], 1);
      check("rst_res_ready", i, act_rr[i], 0);
    end
    step();

    // Single mispredicted branch trains counter 0x10 and repairs history.
    drive(1'b1, 32'h40, 1'b0, 1'b0); step();
    drive(1'b0, 32'h40, 1'b1, 1'b1); #1;
    check("mis_blocks_ready", 1, act_pr[1], 0);
    step();
    drive(1'b0, 32'h44, 1'b0, 1'b0); #1;
    check("mis_pulse", 1, act_mp[1], 1);
    check("mis_total", 1, act_tot[1], 1);
    check("mis_correct", 1, act_cor[1], 0);
    check("mis_pred_0x44", 1, act_pt[1], 1);
    check("model_ctr10", 1, tbl_m[1][16], 2);
    check("model_ghr", 1, ghr_m[1], 1);
    step();
    check("mis_pulse_end", 1, act_mp[1], 0);

    // Fill to depth, reject the extra request, then drain exactly four.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 32'h40 + 32'(4 * k), 1'b0, 1'b0); step();
    end
    drive(1'b1, 32'h200, 1'b0, 1'b0); #1;
    check("full_ready", 1, act_pr[1], 0);
    check("full_ready", 0, act_pr[0], 0);
    step();
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 32'h0, 1'b1, 1'b0); step();
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0); #1;
    check("drain_empty", 1, act_rr[1], 0);
    check("drain_total", 1, act_tot[1], 4);
    check("drain_correct", 1, act_cor[1], 4);
    step();

    // Mispredict of the oldest of three flushes everything.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 32'h40 + 32'(4 * k), 1'b0, 1'b0); step();
    end
    drive(1'b1, 32'h4C, 1'b1, 1'b1); #1;
    check("flush_req_block", 1, act_pr[1], 0);
    step();
    drive(1'b0, 32'h44, 1'b0, 1'b0); #1;
    check("flush_res_ready", 1, act_rr[1], 0);
    check("flush_pulse", 1, act_mp[1], 1);
    check("flush_ghr_pred", 1, act_pt[1], 1);
    step();

    // Concatenated hash: saturate counter {1111,0000}, then weaken it once.
    do_reset();
    for (int k = 0; k < 10; k++) pair(32'h80, 1'b1);
    drive(1'b0, 32'h80, 1'b0, 1'b0); #1;
    check("sat_pred", 0, act_pt[0], 1);
    check("sat_total", 0, act_tot[0], 10);
    check("sat_correct", 0, act_cor[0], 5);
    check("model_ctrF0", 0, tbl_m[0][240], 3);
    step();
    pair(32'h80, 1'b0);
    check("model_ctrF0_nt", 0, tbl_m[0][240], 2);
    check("model_ghr_nt", 0, ghr_m[0], 14);
    for (int k = 0; k < 4; k++) pair(32'h80, 1'b1);
    drive(1'b0, 32'h80, 1'b0, 1'b0); #1;
    check("weak_pred", 0, act_pt[0], 1);
    check("model_ghr_back", 0, ghr_m[0], 15);
    step();

    // Asynchronous reset mid-cycle with two entries pending.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 32'h40 + 32'(4 * k), 1'b0, 1'b0); step();
    end
    drive(1'b0, 32'h0, 1'b1, 1'b0); step();
    drive(1'b0, 32'h0, 1'b0, 1'b0); #1;
    check("pre_rst_total", 1, act_tot[1], 1);
    check("pre_rst_pending", 1, act_rr[1], 1);
    #1;
    reset = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      check("arst_res_ready", i, act_rr[i], 0);
      check("arst_total", i, act_tot[i], 0);
      check("arst_correct", i, act_cor[i], 0);
    end
    step();
    reset = 1'b1;
    step();
    step();

    checking = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule

// File: doc/gshare_branch_predictor.md
GSHARE_BRANCH_PREDICTOR -- requirements
Module: gshare_branch_predictor

Interface
REQ-001 Parameter R, default 8: table index bits; the table SHALL hold 2^R counters.
REQ-002 Parameter H, default 4: global history register (GHR) bits, legal range 1..R.
REQ-003 Parameter N, default 2: saturating counter width, legal range 1..4.
REQ-004 Parameter D, default 4: pending-prediction FIFO depth, a power of 2, minimum 2.
REQ-005 Parameter HASH, default 1: 0 = concatenated index {GHR, PC[R-H+1:2]}; 1 = gshare index PC[R+1:2] XOR zero-extended GHR.
REQ-006 clk  input  1  sole clock, rising edge.
REQ-007 reset  input  1  asynchronous, active-low reset.
REQ-008 pred_valid  input  1  prediction request.
REQ-009 pred_pc  input  32  branch PC.
REQ-010 pred_ready  output  1  request accepted this cycle when high with pred_valid.
REQ-011 pred_taken  output  1  combinational prediction for pred_pc.
REQ-012 res_valid  input  1  resolution of the oldest pending branch.
REQ-013 res_taken  input  1  actual outcome.
REQ-014 res_ready  output  1  high when the FIFO is not empty.
REQ-015 mispredict  output  1  registered one-cycle pulse.
REQ-016 count_total, count_correct  output  32 each  resolution statistics.

Function
REQ-017 pred_taken SHALL be the MSB of the counter at the index computed from pred_pc and the speculative GHR, with no bypass of a same-cycle update.
REQ-018 pred_ready SHALL be the AND of (FIFO not full) and NOT (res_valid AND res_ready AND res_taken != stored prediction of the head entry).
REQ-019 On accept, the block SHALL push {index, pred_taken, GHR snapshot} and shift GHR left with pred_taken entering bit 0.
REQ-020 On resolve (res_valid AND res_ready), the block SHALL pop the head and update the counter at the stored index: increment if taken, decrement if not, saturating at 0 and 2^N-1.
REQ-021 A resolve SHALL increment count_total by 1 and, if res_taken equals the stored prediction, increment count_correct by 1; both counters wrap modulo 2^32.
REQ-022 On a mispredicting resolve, the block SHALL flush all FIFO entries and set GHR to {snapshot[H-2:0], res_taken}, or to res_taken alone when H=1.
REQ-023 On a mispredicting resolve, mispredict SHALL be 1 for exactly the following cycle; otherwise it SHALL be 0.
REQ-024 A simultaneous accept and correct resolve SHALL perform both, the GHR shift using the speculative value; FIFO occupancy is unchanged.
REQ-025 When full, a request SHALL NOT be accepted even if a pop occurs in the same cycle.
REQ-026 res_valid while the FIFO is empty SHALL be ignored: no state or statistics change.
REQ-027 FIFO pointers SHALL wrap modulo D.

Reset
REQ-028 When reset=0, the block SHALL asynchronously clear GHR to 0, empty the FIFO, and clear count_total, count_correct and mispredict to 0.
REQ-029 When reset=0, every counter SHALL be asynchronously set to weakly-not-taken, 2^(N-1)-1.
REQ-030 After reset, before any accept: pred_taken=0, pred_ready=1, res_ready=0.

Verification (defaults unless stated)
REQ-031 Reset released, pred_pc=0x100 -> pred_taken=0, pred_ready=1, res_ready=0.
REQ-032 Accept 0x40, then resolve taken -> mispredict=1 for one cycle; counter[0x10] 1->2; GHR=0001; count_total=1, count_correct=0.
REQ-033 4 accepts with no resolve -> pred_ready=0; 5th request is not accepted and GHR is unchanged.
REQ-034 3 accepts (all predicted 0, GHR snapshot 0000 at the first), resolve the first as taken -> next cycle res_ready=0, GHR=0001, a same-cycle request is not accepted.
REQ-035 HASH=0, PC 0x80, 10 consecutive accept/resolve-taken pairs -> pred_taken=1; counter at index {1111,PC[5:2]} stays at 3; one not-taken resolve gives counter 2 and pred_taken still 1.
REQ-036 reset driven low between clock edges with 2 entries pending -> res_ready=0 and the statistics read 0 immediately, with no clock edge.
